imsic_msi_ingress: RTL and testbench

Parametrised MSI ingress stage for the IMSIC in embedded mode. Accepts 32-bit MSI writes, decodes target hart and interrupt file from the address, and validates the identity. Valid MSIs are buffered in a FIFO and issued one per cycle as setipnum / hart one-hot / file select. Unlike the single-channel APLIC→IMSIC path, it serves M, S and VS files across all harts, supports LE and BE seteipnum, applies backpressure, and counts dropped writes.

---
 rtl/imsic_msi_ingress_pkg.sv | 38 +++
 rtl/imsic_msi_fifo.sv | 69 ++++++
 rtl/imsic_msi_ingress.sv | 176 +++++++++++++++++
 tb/tb_imsic_msi_ingress.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_msi_ingress_pkg.sv
// -----------------------------------------------------------------------------
// imsic_msi_ingress_pkg
// Shared IMSIC definitions for the embedded-mode MSI ingress path:
//   - default geometry (harts, guest files, identities, buffer depth)
//   - M / S window bases, seteipnum register offsets, page width
//   - msi_entry_t: one buffered MSI {setipnum, hart_idx, file}
//   - bswap32: byte swap used for the big-endian seteipnum register
// -----------------------------------------------------------------------------
package imsic_msi_ingress_pkg;

  localparam int NR_HARTS    = 4;
  localparam int NR_VS_FILES = 1;
  localparam int NR_SOURCES  = 64;
  localparam int FIFO_DEPTH  = 4;

  localparam logic [31:0] M_BASE_ADDR = 32'h2400_0000;
  localparam logic [31:0] S_BASE_ADDR = 32'h2800_0000;

  localparam int          IMSIC_PAGE_W     = 12;
  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
  localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

  localparam int SETIPNUM_W = $clog2(NR_SOURCES);
  localparam int HART_W     = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
  localparam int FILE_W     = $clog2(NR_VS_FILES + 2);

  // File encoding: 0 = M, 1 = S, 1+g = VS guest g.
  typedef struct packed {
    logic [SETIPNUM_W-1:0] setipnum;
    logic [HART_W-1:0]     hart_idx;
    logic [FILE_W-1:0]     file;
  } msi_entry_t;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// -----------------------------------------------------------------------------
// imsic_msi_fifo
// Generic synchronous FIFO, power-of-two depth, synchronous active-high reset.
// Ports:
//   i_clk, i_rst        clock, synchronous reset (clears pointers and count)
//   i_push, i_data      write request / entry (ignored when full)
//   i_pop               consume head (ignored when empty)
//   o_head              entry at the head (valid when !o_empty)
//   o_full, o_empty     occupancy flags
// -----------------------------------------------------------------------------
module imsic_msi_fifo #(
  parameter type DATA_T = logic [7:0],
  parameter int  Depth  = 4
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_push,
  input  DATA_T i_data,
  input  logic  i_pop,
  output DATA_T o_head,
  output logic  o_full,
  output logic  o_empty
);

  localparam int PTR_W = $clog2(Depth);
  localparam int CNT_W = PTR_W + 1;

  DATA_T             r_mem [Depth];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(Depth));
  assign o_empty = (r_count == CNT_W'(0));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage array; contents are meaningless while empty, so it is not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/imsic_msi_ingress.sv
// -----------------------------------------------------------------------------
// imsic_msi_ingress
// MSI ingress for an embedded-mode IMSIC: decodes 32-bit MSI writes into
// {identity, hart, interrupt file}, buffers valid ones, issues one per cycle,
// and counts (saturating) writes it had to discard.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_valid/o_req_ready           MSI write handshake
//   i_req_addr, i_req_data            write address / data
//   o_msi_valid/i_msi_ready           issue handshake for the buffered head
//   o_setipnum, o_imsic_en, o_select_file  head identity, one-hot hart, file
//   o_drop, o_drop_cnt                discard pulse and saturating count
// -----------------------------------------------------------------------------
module imsic_msi_ingress
  import imsic_msi_ingress_pkg::*;
#(
  parameter int          NrHarts   = NR_HARTS,
  parameter int          NrVSFiles = NR_VS_FILES,
  parameter int          NrSources = NR_SOURCES,
  parameter int          FifoDepth = FIFO_DEPTH,
  parameter logic [31:0] MBaseAddr = M_BASE_ADDR,
  parameter logic [31:0] SBaseAddr = S_BASE_ADDR
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [31:0]                    i_req_addr,
  input  logic [31:0]                    i_req_data,
  output logic                           o_msi_valid,
  input  logic                           i_msi_ready,
  output logic [$clog2(NrSources)-1:0]   o_setipnum,
  output logic [NrHarts-1:0]             o_imsic_en,
  output logic [$clog2(NrVSFiles+2)-1:0] o_select_file,
  output logic                           o_drop,
  output logic [15:0]                    o_drop_cnt
);

  localparam int PAGE_NUM_W = 32 - IMSIC_PAGE_W;
  localparam logic [PAGE_NUM_W-1:0] M_PAGE    = MBaseAddr[31:IMSIC_PAGE_W];
  localparam logic [PAGE_NUM_W-1:0] S_PAGE    = SBaseAddr[31:IMSIC_PAGE_W];
  localparam logic [PAGE_NUM_W-1:0] S_STRIDE  = PAGE_NUM_W'(NrVSFiles + 1);
  localparam logic [PAGE_NUM_W-1:0] HART_LIM  = PAGE_NUM_W'(NrHarts);

  logic [PAGE_NUM_W-1:0]   w_page;
  logic [IMSIC_PAGE_W-1:0] w_off;
  logic [PAGE_NUM_W-1:0]   w_m_hart;
  logic [PAGE_NUM_W-1:0]   w_s_rel;
  logic [PAGE_NUM_W-1:0]   w_s_hart;
  logic [PAGE_NUM_W-1:0]   w_s_guest;
  logic [PAGE_NUM_W-1:0]   w_hart;
  logic [FILE_W-1:0]       w_file;
  logic                    w_in_window;
  logic [31:0]             w_id;
  logic                    w_off_ok;
  logic                    w_msi_ok;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_drop;
  msi_entry_t              w_entry;
  msi_entry_t              w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    r_drop;
  logic [15:0]             r_drop_cnt;

  assign w_page    = i_req_addr[31:IMSIC_PAGE_W];
  assign w_off     = i_req_addr[IMSIC_PAGE_W-1:0];
  assign w_m_hart  = w_page - M_PAGE;
  assign w_s_rel   = w_page - S_PAGE;
  // S window pages are laid out hart-major: NrVSFiles+1 pages (S, guests) per hart.
  assign w_s_hart  = w_s_rel / S_STRIDE;
  assign w_s_guest = w_s_rel % S_STRIDE;

  // Window select; S window sits above the M window, so it is tested first.
  always_comb begin
    w_in_window = 1'b0;
    w_hart      = '0;
    w_file      = '0;
    if (w_page >= S_PAGE) begin
      w_in_window = 1'b1;
      w_hart      = w_s_hart;
      w_file      = FILE_W'(w_s_guest + PAGE_NUM_W'(1));
    end else if (w_page >= M_PAGE) begin
      w_in_window = 1'b1;
      w_hart      = w_m_hart;
      w_file      = '0;
    end else begin
      w_in_window = 1'b0;
      w_hart      = '0;
      w_file      = '0;
    end
  end

  // Register offset selects the identity byte order.
  always_comb begin
    w_id     = i_req_data;
    w_off_ok = 1'b0;
    case (w_off)
      SETEIPNUM_LE_OFF: begin
        w_id     = i_req_data;
        w_off_ok = 1'b1;
      end
      SETEIPNUM_BE_OFF: begin
        w_id     = bswap32(i_req_data);
        w_off_ok = 1'b1;
      end
      default: begin
        w_id     = i_req_data;
        w_off_ok = 1'b0;
      end
    endcase
  end

  assign w_msi_ok = w_in_window & (w_hart < HART_LIM) & w_off_ok &
                    (w_id != 32'd0) & (w_id < 32'(NrSources));

  // Readiness reflects occupancy only; a same-cycle pop never frees a slot.
  assign o_req_ready = ~i_rst & ~w_full;
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_push      = w_accept & w_msi_ok;
  assign w_drop      = w_accept & ~w_msi_ok;

  assign w_entry.setipnum = w_id[SETIPNUM_W-1:0];
  assign w_entry.hart_idx = w_hart[HART_W-1:0];
  assign w_entry.file     = w_file;

  imsic_msi_fifo #(
    .DATA_T (msi_entry_t),
    .Depth  (FifoDepth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (o_msi_valid & i_msi_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_msi_valid = ~w_empty;

  // Head fields are forced to zero when nothing is queued.
  always_comb begin
    o_setipnum    = '0;
    o_select_file = '0;
    o_imsic_en    = '0;
    if (o_msi_valid) begin
      o_setipnum    = w_head.setipnum;
      o_select_file = w_head.file;
      o_imsic_en    = NrHarts'(1) << w_head.hart_idx;
    end else begin
      o_setipnum    = '0;
      o_select_file = '0;
      o_imsic_en    = '0;
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      r_drop <= w_drop;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_drop     = r_drop;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_imsic_msi_ingress.sv
// -----------------------------------------------------------------------------
// tb_imsic_msi_ingress
// Self-checking bench: a queue-based reference model predicts the outputs
// after every clock edge; directed scenarios add literal expectations and
// a randomized phase exercises mixed traffic, backpressure and resets.
// -----------------------------------------------------------------------------
module tb_imsic_msi_ingress;
  import imsic_msi_ingress_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        msi_valid;
  logic        msi_ready;
  logic [SETIPNUM_W-1:0] setipnum;
  logic [NR_HARTS-1:0]   imsic_en;
  logic [FILE_W-1:0]     select_file;
  logic        drop;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  imsic_msi_ingress dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_msi_valid   (msi_valid),
    .i_msi_ready   (msi_ready),
    .o_setipnum    (setipnum),
    .o_imsic_en    (imsic_en),
    .o_select_file (select_file),
    .o_drop        (drop),
    .o_drop_cnt    (drop_cnt)
  );

  typedef struct {
    int id;
    int hart;
    int file;
  } msi_t;

  msi_t m_q[$];
  bit   m_drop;
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: enumerate every legal page and match against it.
  function automatic void model_decode(input logic [31:0] a, input logic [31:0] d,
                                       output bit ok, output int id,
                                       output int hart, output int file);
    bit found = 0;
    logic [31:0] pg;
    logic [31:0] off;
    logic [31:0] v;
    hart = 0;
    file = 0;
    for (int h = 0; h < NR_HARTS; h++) begin
      pg = M_BASE_ADDR + 32'(h) * 32'h1000;
      if ((a & 32'hFFFF_F000) == pg) begin
        found = 1; hart = h; file = 0;
      end
      for (int g = 0; g <= NR_VS_FILES; g++) begin
        pg = S_BASE_ADDR + 32'(h * (NR_VS_FILES + 1) + g) * 32'h1000;
        if ((a & 32'hFFFF_F000) == pg) begin
          found = 1; hart = h; file = 1 + g;
        end
      end
    end
    off = a & 32'h0000_0FFF;
    v = d;
    if (off == 32'h4) v = {d[7:0], d[15:8], d[23:16], d[31:24]};
    ok = found && (off == 32'h0 || off == 32'h4) && v != 32'd0 && v < 32'(NR_SOURCES);
    id = ok ? int'(v) : 0;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit r, input bit v, input logic [31:0] a,
                       input logic [31:0] d, input bit mr);
    bit ok;
    bit acc;
    int id;
    int h;
    int f;
    bit ev;
    rst = r; req_valid = v; req_addr = a; req_data = d; msi_ready = mr;
    acc = v && !r && (m_q.size() < FIFO_DEPTH);
    if (r) begin
      m_q.delete();
      m_drop = 0;
      m_cnt  = 0;
    end else begin
      model_decode(a, d, ok, id, h, f);
      if (m_q.size() > 0 && mr) void'(m_q.pop_front());
      if (acc && ok) m_q.push_back('{id, h, f});
      m_drop = acc && !ok;
      if (m_drop && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    ev = (m_q.size() > 0);
    check("msi_valid", 32'(msi_valid), 32'(ev));
    check("setipnum", 32'(setipnum), ev ? 32'(m_q[0].id) : 32'd0);
    check("imsic_en", 32'(imsic_en), ev ? (32'd1 << m_q[0].hart) : 32'd0);
    check("select_file", 32'(select_file), ev ? 32'(m_q[0].file) : 32'd0);
    check("drop", 32'(drop), 32'(m_drop));
    check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    check("req_ready", 32'(req_ready), 32'(!r && m_q.size() < FIFO_DEPTH));
  endtask

  task automatic idle(input bit mr);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, mr);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int kind;
    int idv;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; msi_ready = 1'b0;
    m_drop = 0; m_cnt = 0;

    // Reset state
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h2400_1000, 32'd5, 1'b0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(msi_valid), 32'd0);
    check("rst_cnt", 32'(drop_cnt), 32'd0);
    idle(1'b1);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // LE write to M file of hart 1
    cycle(1'b0, 1'b1, 32'h2400_1000, 32'd5, 1'b0);
    check("le_valid", 32'(msi_valid), 32'd1);
    check("le_id", 32'(setipnum), 32'd5);
    check("le_en", 32'(imsic_en), 32'b0010);
    check("le_file", 32'(select_file), 32'd0);
    idle(1'b1);

    // BE write to hart 1 guest 1
    cycle(1'b0, 1'b1, 32'h2800_3004, 32'h0700_0000, 1'b1);
    check("be_id", 32'(setipnum), 32'd7);
    check("be_en", 32'(imsic_en), 32'b0010);
    check("be_file", 32'(select_file), 32'd2);
    idle(1'b1);

    // Five drop causes
    cycle(1'b0, 1'b1, 32'h2400_0000, 32'd0, 1'b1);
    check("drop_pulse", 32'(drop), 32'd1);
    cycle(1'b0, 1'b1, 32'h2400_0000, 32'd64, 1'b1);
    cycle(1'b0, 1'b1, 32'h2400_0008, 32'd5, 1'b1);
    cycle(1'b0, 1'b1, 32'h2400_4000, 32'd5, 1'b1);
    cycle(1'b0, 1'b1, 32'h3000_0000, 32'd5, 1'b1);
    check("drop_cnt5", 32'(drop_cnt), 32'd5);
    check("drop_no_valid", 32'(msi_valid), 32'd0);
    idle(1'b1);
    check("drop_one_cycle", 32'(drop), 32'd0);

    // Backpressure: five writes with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 32'h2400_0000 + 32'(i % NR_HARTS) * 32'h1000, 32'(11 + i), 1'b0);
      if (i == 3) check("full_ready", 32'(req_ready), 32'd0);
    end
    check("stall_head", 32'(setipnum), 32'd11);
    cycle(1'b0, 1'b1, 32'h2400_0000, 32'd15, 1'b1);
    check("first_pop_head", 32'(setipnum), 32'd12);
    check("room_after_pop", 32'(req_ready), 32'd1);
    cycle(1'b0, 1'b1, 32'h2400_0000, 32'd15, 1'b1);
    check("second_pop_head", 32'(setipnum), 32'd13);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("drained", 32'(msi_valid), 32'd0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h2400_2000, 32'(20 + i), 1'b0);
    cycle(1'b1, 1'b1, 32'h2400_2000, 32'd30, 1'b0);
    check("mid_rst_valid", 32'(msi_valid), 32'd0);
    check("mid_rst_cnt", 32'(drop_cnt), 32'd0);
    idle(1'b1);
    check("no_stale", 32'(msi_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 4);
      idv  = $urandom_range(0, 70);
      case (kind)
        0: a = M_BASE_ADDR + 32'($urandom_range(0, NR_HARTS)) * 32'h1000;
        1, 2: a = S_BASE_ADDR + 32'($urandom_range(0, NR_HARTS * (NR_VS_FILES + 1) + 1)) * 32'h1000;
        3: a = (($urandom_range(0, 1) == 0) ? M_BASE_ADDR : S_BASE_ADDR) + 32'($urandom_range(0, 3)) * 32'h1000;
        default: a = $urandom;
      endcase
      if (kind != 4) begin
        case ($urandom_range(0, 5))
          0, 1: a = a + 32'h0;
          2, 3: a = a + 32'h4;
          4: a = a + 32'h8;
          default: a = a + 32'($urandom_range(0, 4095));
        endcase
      end
      d = 32'(idv);
      if ((a & 32'hFFF) == 32'h4) d = {d[7:0], d[15:8], d[23:16], d[31:24]};
      if ($urandom_range(0, 15) == 0) d = $urandom;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), a, d,
            ($urandom_range(0, 2) != 0));
    end

    // Saturation of the drop counter
    for (int n = 0; n < 65540; n++) begin
      cycle(1'b0, 1'b1, 32'h3000_0000, 32'd5, 1'b1);
    end
    check("drop_sat", 32'(drop_cnt), 32'h0000_FFFF);
    idle(1'b1);
    check("drop_sat_hold", 32'(drop_cnt), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
